// File: rtl/tl_port_drain_arbiter.sv
// tl_port_drain_arbiter: round-robin drain of four transfer-layer FIFOs onto one registered stream with per-port counters
module tl_port_drain_arbiter #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              emptyP0,
  input  logic              emptyP1,
  input  logic              emptyP2,
  input  logic              emptyP3,
  input  logic [DATA_W-1:0] dataOutputP0,
  input  logic [DATA_W-1:0] dataOutputP1,
  input  logic [DATA_W-1:0] dataOutputP2,
  input  logic [DATA_W-1:0] dataOutputP3,
  input  logic              pauseIn,
  output logic              popOutP0,
  output logic              popOutP1,
  output logic              popOutP2,
  output logic              popOutP3,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic [1:0]        portOut,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic [CNT_W-1:0]  counterOut,
  output logic              counterValid,
  output logic              idleOut
);
  typedef enum logic [1:0] {IDLE, INIT, ACTIVE} state_t;
  state_t state, state_n;
  logic [1:0] ptr, gnt, p1;
  logic gnt_v, v1;
  logic [3:0] pop, emp, inc;
  logic [CNT_W-1:0] cnt [4];
  logic [DATA_W-1:0] din [4];
  assign emp = {emptyP3, emptyP2, emptyP1, emptyP0};
  assign din[0] = dataOutputP0;
  assign din[1] = dataOutputP1;
  assign din[2] = dataOutputP2;
  assign din[3] = dataOutputP3;
  assign {popOutP3, popOutP2, popOutP1, popOutP0} = pop;
  assign inc = validOut ? 4'b0001 << portOut : 4'b0000;
  // later iterations overwrite earlier ones, so the port nearest ptr+1 wins
  always_comb begin
    state_n = init ? INIT : (state == IDLE ? IDLE : ACTIVE);
    gnt_v = 1'b0;
    gnt = ptr;
    if (state == ACTIVE && !pauseIn)
      for (int k = 4; k >= 1; k--)
        if (!emp[ptr + 2'(k)]) begin
          gnt_v = 1'b1;
          gnt = ptr + 2'(k);
        end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= 2'd3;
      pop <= '0;
      v1 <= 1'b0;
      p1 <= '0;
      dataOut <= '0;
      validOut <= 1'b0;
      portOut <= '0;
      counterOut <= '0;
      counterValid <= 1'b0;
      idleOut <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      state <= state_n;
      pop <= gnt_v ? 4'b0001 << gnt : 4'b0000;
      ptr <= state == INIT ? 2'd3 : (gnt_v ? gnt : ptr);
      v1 <= |pop;
      p1 <= {pop[3] | pop[2], pop[3] | pop[1]};
      validOut <= v1;
      if (v1) begin
        dataOut <= din[p1];
        portOut <= p1;
      end
      // read uses pre-increment values; INIT clears but still counts a word landing that cycle
      for (int i = 0; i < 4; i++)
        cnt[i] <= state == INIT ? CNT_W'(inc[i]) :
                  (inc[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
      counterValid <= req && idx != 3'd0 && idx <= 3'd4;
      if (req && idx != 3'd0 && idx <= 3'd4) counterOut <= cnt[idx[1:0] - 2'd1];
      idleOut <= state == ACTIVE && &emp && ~|pop && !v1 && !validOut;
    end
  end
endmodule

// File: tb/tb_tl_port_drain_arbiter.sv
// tb_tl_port_drain_arbiter: randomized and directed checks against a transaction-level round-robin model
module tb_tl_port_drain_arbiter;
  localparam int DW = 12;
  localparam int CW = 5;
  typedef struct packed {logic [1:0] p; logic [DW-1:0] d;} item_t;
  logic clk = 0, reset = 0, init = 0, pauseIn = 0, req = 0;
  logic [2:0] idx = 0;
  logic [3:0] emp, pops;
  logic [DW-1:0] dout_m [4];
  logic [DW-1:0] pend [4];
  logic popOutP0, popOutP1, popOutP2, popOutP3, validOut, counterValid, idleOut;
  logic [DW-1:0] dataOut;
  logic [1:0] portOut;
  logic [CW-1:0] counterOut;
  logic [DW-1:0] q [4][$];
  item_t exp_q[$], got_q[$];
  int got_cyc[$];
  int vectors = 0, errors = 0, cyc = 0, m_ptr = 3;
  int m_cnt [4];

  tl_port_drain_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .emptyP0(emp[0]), .emptyP1(emp[1]), .emptyP2(emp[2]), .emptyP3(emp[3]),
    .dataOutputP0(dout_m[0]), .dataOutputP1(dout_m[1]), .dataOutputP2(dout_m[2]), .dataOutputP3(dout_m[3]),
    .pauseIn(pauseIn),
    .popOutP0(popOutP0), .popOutP1(popOutP1), .popOutP2(popOutP2), .popOutP3(popOutP3),
    .dataOut(dataOut), .validOut(validOut), .portOut(portOut),
    .req(req), .idx(idx), .counterOut(counterOut), .counterValid(counterValid), .idleOut(idleOut)
  );

  assign pops = {popOutP3, popOutP2, popOutP1, popOutP0};
  always #5 clk = ~clk;

  function automatic void upd_empty();
    for (int i = 0; i < 4; i++) emp[i] = (q[i].size() == 0);
  endfunction

  // FIFO model: empty reflects a pop as soon as it is issued, data appears the following cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      dout_m[i] = pend[i];
      if (pops[i]) begin
        vectors++;
        if (q[i].size() == 0) begin
          errors++;
          $display("FAIL pop_empty: port %0d popped while fifo empty, required no pop", i);
        end else pend[i] = q[i].pop_front();
      end
    end
    upd_empty();
  end

  always @(negedge clk) begin
    vectors++;
    if ($countones(pops) > 1) begin
      errors++;
      $display("FAIL pop_onehot: pops=%b, required at most one set", pops);
    end
    if (reset && validOut) begin
      got_q.push_back({portOut, dataOut});
      got_cyc.push_back(cyc);
      vectors++;
      if (idleOut !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy: idleOut=%b with validOut, required 0", idleOut);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push(input int p, input logic [DW-1:0] w);
    q[p].push_back(w);
    upd_empty();
  endtask

  // transaction-level round robin: scan ptr+1.. for the next non-empty FIFO
  task automatic model_run();
    logic [DW-1:0] mq [4][$];
    bit any;
    for (int i = 0; i < 4; i++) mq[i] = q[i];
    do begin
      any = 0;
      for (int k = 1; k <= 4; k++) begin
        int p;
        p = (m_ptr + k) % 4;
        if (mq[p].size() != 0) begin
          exp_q.push_back({2'(p), mq[p].pop_front()});
          m_ptr = p;
          if (m_cnt[p] < 31) m_cnt[p]++;
          any = 1;
          break;
        end
      end
    end while (any);
  endtask

  task automatic do_init();
    @(negedge clk); init = 1;
    @(negedge clk); init = 0;
    @(negedge clk);
    m_ptr = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic drain(input bit chk_b2b, input bit rnd_pause);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 600) begin
      @(negedge clk);
      if (rnd_pause) pauseIn = ($urandom_range(0, 3) == 0);
      t++;
    end
    pauseIn = 0;
    repeat (6) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drain_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stream[%0d]: port %0d data %h, required port %0d data %h",
                 i, got_q[i].p, got_q[i].d, exp_q[i].p, exp_q[i].d);
      end
    end
    if (chk_b2b && got_q.size() > 1) begin
      vectors++;
      if (got_cyc[got_cyc.size()-1] - got_cyc[0] != got_q.size() - 1) begin
        errors++;
        $display("FAIL throughput: %0d words spanned %0d cycles, required %0d",
                 got_q.size(), got_cyc[got_cyc.size()-1] - got_cyc[0] + 1, got_q.size());
      end
    end
    vectors++;
    if (idleOut !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_drain: idleOut=%b, required 1", idleOut);
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic read_cnt(input int i);
    @(negedge clk); req = 1; idx = 3'(i + 1);
    @(negedge clk); req = 0; idx = 0;
    vectors++;
    if (counterValid !== 1'b1 || counterOut !== CW'(m_cnt[i])) begin
      errors++;
      $display("FAIL counter_read[%0d]: valid=%b value=%0d, required valid=1 value=%0d",
               i, counterValid, counterOut, m_cnt[i]);
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({pops, dataOut, validOut, portOut, counterOut, counterValid, idleOut} !== '0) begin
      errors++;
      $display("FAIL %s: pops=%b data=%h valid=%b port=%0d cnt=%0d cvalid=%b idle=%b, required all 0",
               name, pops, dataOut, validOut, portOut, counterOut, counterValid, idleOut);
    end
  endtask

  task automatic check_no_pop(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      vectors++;
      if (pops !== 4'b0 || validOut !== 1'b0) begin
        errors++;
        $display("FAIL %s: pops=%b valid=%b, required 0 and 0", name, pops, validOut);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    check_all_zero("reset_state");
    @(negedge clk); reset = 1;
    push(0, 12'h123);
    check_no_pop("idle_no_pop", 5);
    q[0].delete(); upd_empty();
  endtask

  task automatic test_p0_two();
    do_init();
    push(0, 12'd15); push(0, 12'd20);
    model_run();
    drain(1, 0);
    read_cnt(0);
    read_cnt(1);
  endtask

  task automatic test_four_ports();
    do_init();
    push(0, 12'h00F); push(1, 12'h014); push(2, 12'h019); push(3, 12'h01E);
    model_run();
    drain(1, 0);
    for (int i = 0; i < 4; i++) read_cnt(i);
  endtask

  task automatic test_alternate();
    do_init();
    for (int i = 0; i < 3; i++) begin
      push(1, 12'($urandom)); push(3, 12'($urandom));
    end
    model_run();
    drain(1, 0);
  endtask

  task automatic test_pause();
    int t = 0, nv = 0;
    do_init();
    push(2, 12'h5FF); push(2, 12'hAFF); push(2, 12'hFFF);
    model_run();
    do begin @(negedge clk); t++; end while (pops == 4'b0 && t < 20);
    vectors++;
    if (pops !== 4'b0100) begin
      errors++;
      $display("FAIL pause_first_pop: pops=%b, required 0100", pops);
    end
    pauseIn = 1;
    repeat (4) begin
      @(negedge clk);
      if (validOut) nv++;
      vectors++;
      if (pops !== 4'b0) begin
        errors++;
        $display("FAIL pause_pops: pops=%b, required 0000", pops);
      end
    end
    vectors++;
    if (nv > 2) begin
      errors++;
      $display("FAIL pause_inflight: %0d words during pause, required at most 2", nv);
    end
    pauseIn = 0;
    drain(0, 0);
  endtask

  task automatic test_saturate();
    do_init();
    for (int i = 0; i < 33; i++) push(0, 12'($urandom));
    model_run();
    drain(1, 0);
    read_cnt(0);
    do_init();
    read_cnt(0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); req = 1; idx = (k == 0) ? 3'd0 : 3'd5;
      @(negedge clk); req = 0; idx = 0;
      vectors++;
      if (counterValid !== 1'b0 || counterOut !== 5'd0) begin
        errors++;
        $display("FAIL bad_idx: valid=%b value=%0d, required valid=0 value held at 0", counterValid, counterOut);
      end
    end
  endtask

  task automatic test_random();
    do_init();
    repeat (6) begin
      for (int p = 0; p < 4; p++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) push(p, 12'($urandom));
      end
      model_run();
      drain(0, 1);
      @(negedge clk); req = 1; idx = 3'd1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 4) req = 0; else idx = 3'(k + 1);
        vectors++;
        if (counterValid !== 1'b1 || counterOut !== CW'(m_cnt[k-1])) begin
          errors++;
          $display("FAIL held_read[%0d]: valid=%b value=%0d, required valid=1 value=%0d",
                   k - 1, counterValid, counterOut, m_cnt[k-1]);
        end
      end
      idx = 0;
    end
  endtask

  task automatic test_async_reset();
    int t = 0;
    for (int p = 0; p < 4; p++) for (int j = 0; j < 4; j++) push(p, 12'($urandom));
    do begin @(negedge clk); t++; end while (!validOut && t < 20);
    #2 reset = 0;
    #1 check_all_zero("async_reset");
    @(negedge clk); reset = 1;
    for (int i = 0; i < 4; i++) q[i].delete();
    upd_empty();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    m_ptr = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    push(1, 12'h3C3);
    check_no_pop("post_reset_no_pop", 5);
    do_init();
    model_run();
    drain(1, 0);
    read_cnt(1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pend[i] = '0; dout_m[i] = '0; m_cnt[i] = 0;
    end
    upd_empty();
    test_reset();
    test_p0_two();
    test_four_ports();
    test_alternate();
    test_pause();
    test_saturate();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/tl_port_drain_arbiter.md
Name: tl_port_drain_arbiter

Overview:
Downstream consumer of the transaction-layer transfer block. Drains its four 12-bit output FIFOs (P0..P3) by round-robin, issuing popOutP0..popOutP3. Serializes the popped words onto a single registered stream toward the link stage and keeps per-port forwarded-word counters that can be read by index.

Parameters:
DATA_W, 12, word width (matches transfer-layer FIFO width)
CNT_W, 5, width of per-port forwarded-word counters

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset; 0 = in reset
init  in  1  one-cycle pulse; enters INIT state (clears counters and RR pointer)
emptyP0..emptyP3  in  1 each  FIFO empty flags from transfer layer
dataOutputP0..dataOutputP3  in  DATA_W each  FIFO read data; valid the cycle after pop
pauseIn  in  1  downstream backpressure; 1 = issue no new pops
popOutP0..popOutP3  out  1 each  registered pop strobes to transfer-layer FIFOs
dataOut  out  DATA_W  serialized word
validOut  out  1  dataOut qualifier, one cycle per word
portOut  out  2  source port of current dataOut
req  in  1  counter read request
idx  in  3  counter select: 1..4 selects P0..P3
counterOut  out  CNT_W  selected counter value
counterValid  out  1  counterOut qualifier
idleOut  out  1  ACTIVE, all FIFOs empty, no word in flight

Behaviour:
- Reset (reset=0, async): state=IDLE; all pops=0, dataOut=0, validOut=0, portOut=0, counterOut=0, counterValid=0, idleOut=0; counters=0; RR pointer=3, so P0 has first priority.
- States:
  - IDLE: no pops; init=1 -> INIT.
  - INIT: one cycle; counters=0, pointer=3; -> ACTIVE.
  - ACTIVE: arbitrate; init=1 -> INIT.
- Arbitration in ACTIVE:
  - Each cycle with pauseIn=0, grant the first port with empty=0, searching pointer+1, pointer+2, ... modulo 4.
  - Register that port's pop for the next cycle and update pointer to the granted port.
  - At most one pop per cycle, one-hot across popOutP*.
  - No eligible port or pauseIn=1 -> all pops 0; pointer unchanged.
- FIFO contract: the empty flag reflects a pop at the edge ending the pop cycle. Back-to-back pops of the same port are legal.
- Latency:
  - pop high in cycle c -> word on dataOutputPi in cycle c+1.
  - Block registers it -> dataOut/validOut/portOut in cycle c+2.
  - Sustained 1 word/cycle.
- validOut low -> dataOut holds its last value; portOut holds.
- pauseIn only blocks new pops. Words already popped (up to 2 in flight) are still delivered.
- Counters:
  - Counter[portOut] increments by 1 in each cycle validOut=1.
  - Counters saturate at 2^CNT_W-1 (31); no wrap.
  - INIT clears counters. In-flight words delivered after INIT are counted into the cleared counters.
  - Pops issued in the INIT cycle: none.
- Counter read:
  - req=1 with idx in 1..4 in cycle c -> counterOut = counter[idx-1] and counterValid=1 in cycle c+1.
  - The read returns the counter value sampled at the edge, i.e. before any same-cycle increment.
  - idx=0 or 5..7, or req=0 -> counterValid=0, counterOut holds.
  - req held high with changing idx -> one result per cycle.
- idleOut: registered; 1 in ACTIVE when all empty=1, no pop issued last cycle, and no word in pipeline.
- Mid-operation async reset clears everything immediately. In-flight words are dropped.
- init while in IDLE/INIT: re-enter INIT.

Test Plan:
- Reset, init; P0 holds 15,20 and others empty -> pops P0 twice in consecutive cycles; dataOut 15 then 20 with validOut, portOut=0; counter0=2; idleOut rises after.
- P0..P3 each hold 1 word (0x00F, 0x014, 0x019, 0x01E) -> grant order P0,P1,P2,P3; four consecutive validOut cycles in that order; every counter=1.
- Only P1 and P3 non-empty with 3 words each -> alternating P1,P3,P1,P3,P1,P3; no pop to empty ports.
- Streaming from P2 while pauseIn rises for 4 cycles -> pops stop the next cycle; at most 2 further validOut words; resume with no loss or duplication (compare sequence 0x5FF, 0xAFF, 0xFFF).
- 33 words from P0 -> counter0 saturates at 31. Then init -> counter0 reads 0 via req=1, idx=1 one cycle later. req with idx=0 -> counterValid=0.
- Assert reset=0 asynchronously mid-stream -> all outputs 0 immediately; pops blocked until a new init.
